cache_2way_wb: RTL

//  Parametrised 2-way set-associative, write-back, write-allocate data cache between

---
 rtl/cache_2way_wb_pkg.sv | 22 ++
 rtl/cache_2way_wb_if.sv | 33 +++
 rtl/cache_2way_wb_way.sv | 64 ++++++
 rtl/cache_2way_wb.sv | 131 +++++++++++++
 4 files changed

// File: rtl/cache_2way_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_2way_wb_pkg
// Brief  : Shared constants, FSM encodings and field helpers for the cache.
// Rev    : 1.0  initial release
// ============================================================================
package cache_2way_wb_pkg;

  localparam int WORD_W = 32;
  localparam int BLK_W  = 128;
  localparam int OFF_W  = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WBACK = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;

  function automatic int tag_w(input int addr_w, input int set_bits);
    return addr_w - OFF_W - set_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_2way_wb_if.sv
`default_nettype none
// ============================================================================
// Module : cache_2way_wb_if
// Brief  : Processor and memory-side signal bundle of the write-back cache.
// Rev    : 1.0  initial release
// ============================================================================
interface cache_2way_wb_if #(
  parameter int ADDR_W = 30
);
  logic              proc_read;
  logic              proc_write;
  logic [ADDR_W-1:0] proc_addr;
  logic [31:0]       proc_wdata;
  logic [31:0]       proc_rdata;
  logic              proc_stall;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-3:0] mem_addr;
  logic [127:0]      mem_wdata;
  logic [127:0]      mem_rdata;
  logic              mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/cache_2way_wb_way.sv
`default_nettype none
// ============================================================================
// Module : cache_2way_wb_way
// Brief  : One way: valid/dirty/tag/data storage, word write, block fill, hit.
// Rev    : 1.0  initial release
// ============================================================================
module cache_2way_wb_way
  import cache_2way_wb_pkg::*;
#(
  parameter int SET_BITS = 2,
  parameter int TAG_W    = 26
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  input  wire logic [SET_BITS-1:0] index,
  input  wire logic [TAG_W-1:0]    req_tag,
  input  wire logic                word_we,
  input  wire logic [1:0]          word_sel,
  input  wire logic [WORD_W-1:0]   word_data,
  input  wire logic                fill_en,
  input  wire logic [BLK_W-1:0]    fill_data,
  output logic                     hit,
  output logic                     valid,
  output logic                     dirty,
  output logic [TAG_W-1:0]         tag,
  output logic [BLK_W-1:0]         data
);
  localparam int SETS = 1 << SET_BITS;

  logic [SETS-1:0]  r_valid;
  logic [SETS-1:0]  r_dirty;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [BLK_W-1:0] r_data [SETS];

  // Only the status bits are cleared; tag/data are meaningless while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (fill_en) begin
      r_valid[index] <= 1'b1;
      r_dirty[index] <= 1'b0;
    end else if (word_we) begin
      r_dirty[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      r_tag[index]  <= req_tag;
      r_data[index] <= fill_data;
    end else if (word_we) begin
      r_data[index][{word_sel, 5'b0} +: WORD_W] <= word_data;
    end
  end

  assign valid = r_valid[index];
  assign dirty = r_dirty[index];
  assign tag   = r_tag[index];
  assign data  = r_data[index];
  assign hit   = r_valid[index] && (r_tag[index] == req_tag);

endmodule
`default_nettype wire

// File: rtl/cache_2way_wb.sv
`default_nettype none
// ============================================================================
// Module : cache_2way_wb
// Brief  : 2-way set-associative write-back/write-allocate cache with LRU.
// Rev    : 1.0  initial release
// ============================================================================
module cache_2way_wb
  import cache_2way_wb_pkg::*;
#(
  parameter int ADDR_W   = 30,
  parameter int SET_BITS = 2
) (
  input  wire logic       clk,
  input  wire logic       proc_reset_n,
  cache_2way_wb_if.slave  bus
);
  localparam int TAG_W = tag_w(ADDR_W, SET_BITS);
  localparam int SETS  = 1 << SET_BITS;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic                r_victim;
  logic [SETS-1:0]     r_lru;

  logic [SET_BITS-1:0] w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [1:0]          w_word;
  logic                w_req;
  logic [1:0]          w_hit;
  logic [1:0]          w_valid;
  logic [1:0]          w_dirty;
  logic [1:0]          w_word_we;
  logic [1:0]          w_fill_en;
  logic [TAG_W-1:0]    w_way_tag  [2];
  logic [BLK_W-1:0]    w_way_data [2];
  logic                w_hit_any;
  logic                w_hit_way;
  logic                w_victim;
  logic [BLK_W-1:0]    w_hit_blk;
  logic [WORD_W-1:0]   w_hit_word;

  assign w_index   = bus.proc_addr[SET_BITS+1:2];
  assign w_tag     = bus.proc_addr[ADDR_W-1:SET_BITS+2];
  assign w_word    = bus.proc_addr[1:0];
  assign w_req     = bus.proc_read | bus.proc_write;
  assign w_hit_any = w_hit[0] | w_hit[1];
  assign w_hit_way = w_hit[1];
  assign w_hit_blk = w_way_data[w_hit_way];
  assign w_hit_word = w_hit_blk[{w_word, 5'b0} +: WORD_W];
  // Fill empty ways first so LRU only matters once the set is full.
  assign w_victim  = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_index]);

  for (genvar g = 0; g < 2; g++) begin : g_way
    assign w_word_we[g] = (r_state == S_IDLE) && bus.proc_write && w_hit[g];
    assign w_fill_en[g] = (r_state == S_ALLOC) && bus.mem_ready && (r_victim == 1'(g));

    cache_2way_wb_way #(.SET_BITS(SET_BITS), .TAG_W(TAG_W)) u_way (
      .clk       (clk),
      .rst_n     (proc_reset_n),
      .index     (w_index),
      .req_tag   (w_tag),
      .word_we   (w_word_we[g]),
      .word_sel  (w_word),
      .word_data (bus.proc_wdata),
      .fill_en   (w_fill_en[g]),
      .fill_data (bus.mem_rdata),
      .hit       (w_hit[g]),
      .valid     (w_valid[g]),
      .dirty     (w_dirty[g]),
      .tag       (w_way_tag[g]),
      .data      (w_way_data[g])
    );
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      r_state  <= S_IDLE;
      r_victim <= 1'b0;
      r_lru    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_req) begin
        if (w_hit_any) r_lru[w_index] <= ~w_hit_way;
        else           r_victim       <= w_victim;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req && !w_hit_any)
                 w_next = (w_valid[w_victim] && w_dirty[w_victim]) ? S_WBACK : S_ALLOC;
      S_WBACK: if (bus.mem_ready) w_next = S_ALLOC;
      S_ALLOC: if (bus.mem_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so an aborted transfer drops at once.
  always_comb begin
    bus.proc_rdata = '0;
    bus.proc_stall = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (proc_reset_n) begin
      case (r_state)
        S_IDLE: begin
          bus.proc_stall = w_req & ~w_hit_any;
          if (bus.proc_read && w_hit_any) bus.proc_rdata = w_hit_word;
        end
        S_WBACK: begin
          bus.proc_stall = 1'b1;
          bus.mem_write  = 1'b1;
          bus.mem_addr   = {w_way_tag[r_victim], w_index};
          bus.mem_wdata  = w_way_data[r_victim];
        end
        S_ALLOC: begin
          bus.proc_stall = 1'b1;
          bus.mem_read   = 1'b1;
          bus.mem_addr   = {w_tag, w_index};
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
